// File: rtl/shift_rotate_unit_if.sv
// Handshake bundle for the shift/rotate unit: operation request side and result side.
// master drives requests and out_ready; slave is the unit itself.
interface shift_rotate_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [31:0]      in_amount;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amount, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amount, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_illegal, out_tag
  );
endinterface

// File: rtl/shift_rotate_unit.sv
// Two-stage pipelined barrel shift/rotate unit with valid/ready flow control.
// Every op is done as a right rotation followed by a fill mask for the shifts.
module shift_rotate_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clock,
  input  logic               clear,
  shift_rotate_unit_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned S1L = (SHW + 1) / 2;

  localparam logic [2:0] OpRor  = 3'b000;
  localparam logic [2:0] OpRol  = 3'b001;
  localparam logic [2:0] OpShr  = 3'b010;
  localparam logic [2:0] OpShl  = 3'b011;
  localparam logic [2:0] OpShra = 3'b100;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [SHW-1:S1L] s1_rot_hi_q;
  logic [SHW-1:0]   s1_n_q;
  logic             s1_sat_q;
  logic             s1_sign_q;
  logic [2:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;
  logic             out_illegal_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             s2_adv;
  logic             s1_adv;
  logic [SHW-1:0]   amt_lo;
  logic             amt_sat;
  logic [SHW-1:0]   rot;
  logic [WIDTH-1:0] s1_next;
  logic [WIDTH-1:0] res;
  logic             fill;

  assign s2_adv  = !out_valid_q || bus.out_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign amt_lo  = bus.in_amount[SHW-1:0];
  assign amt_sat = |bus.in_amount[31:SHW];

  // Left-going ops rotate right by the negated count; illegal ops do not rotate.
  always_comb begin
    rot = '0;
    case (bus.in_op)
      OpRor, OpShr, OpShra: rot = amt_lo;
      OpRol, OpShl:         rot = -amt_lo;
      default:              rot = '0;
    endcase
    s1_next = bus.in_data;
    for (int l = 0; l < int'(S1L); l++) begin
      if (rot[l]) begin
        s1_next = (s1_next >> (1 << l)) | (s1_next << (WIDTH - (1 << l)));
      end
    end
  end

  always_comb begin
    res = s1_data_q;
    for (int l = int'(S1L); l < int'(SHW); l++) begin
      if (s1_rot_hi_q[l]) begin
        res = (res >> (1 << l)) | (res << (WIDTH - (1 << l)));
      end
    end
    fill = (s1_op_q == OpShra) && s1_sign_q;
    // Bits that wrapped around during the rotation are replaced by the fill value.
    for (int i = 0; i < int'(WIDTH); i++) begin
      case (s1_op_q)
        OpShr, OpShra: begin
          if (s1_sat_q || (i + int'(s1_n_q) >= int'(WIDTH))) res[i] = fill;
        end
        OpShl: begin
          if (s1_sat_q || (i < int'(s1_n_q))) res[i] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_rot_hi_q <= '0;
      s1_n_q      <= '0;
      s1_sat_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_op_q     <= '0;
      s1_tag_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_q   <= s1_next;
        s1_rot_hi_q <= rot[SHW-1:S1L];
        s1_n_q      <= amt_lo;
        s1_sat_q    <= amt_sat;
        s1_sign_q   <= bus.in_data[WIDTH-1];
        s1_op_q     <= bus.in_op;
        s1_tag_q    <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
      out_tag_q     <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q    <= res;
        out_zero_q    <= (res == '0);
        out_illegal_q <= (s1_op_q > OpShra);
        out_tag_q     <= s1_tag_q;
      end
    end
  end

  assign bus.in_ready    = s1_adv;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.out_tag     = out_tag_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench for shift_rotate_unit: arithmetic reference model plus scoreboard,
// directed vectors, back-pressure, illegal-op and mid-stream reset scenarios.
module tb_shift_rotate_unit;
  localparam int unsigned W  = 32;
  localparam int unsigned TW = 4;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  shift_rotate_unit_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  shift_rotate_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic          zero;
    logic          illegal;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [31:0] amt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16] = '{
    '{3'd0, 32'h80000001, 32'd1,          32'hC0000000},
    '{3'd0, 32'h80000001, 32'd33,         32'hC0000000},
    '{3'd1, 32'h80000001, 32'd4,          32'h00000018},
    '{3'd3, 32'h00000001, 32'd31,         32'h80000000},
    '{3'd2, 32'hF0000000, 32'd4,          32'h0F000000},
    '{3'd4, 32'h80000000, 32'd40,         32'hFFFFFFFF},
    '{3'd2, 32'h12345678, 32'd32,         32'h00000000},
    '{3'd4, 32'h7FFFFFFF, 32'hFFFFFFFF,   32'h00000000},
    '{3'd5, 32'hDEADBEEF, 32'd3,          32'hDEADBEEF},
    '{3'd1, 32'h12345678, 32'd0,          32'h12345678},
    '{3'd4, 32'h80000000, 32'd4,          32'hF8000000},
    '{3'd3, 32'h12345678, 32'd8,          32'h34567800},
    '{3'd0, 32'h12345678, 32'd8,          32'h78123456},
    '{3'd1, 32'h12345678, 32'd8,          32'h34567812},
    '{3'd2, 32'h80000000, 32'd31,         32'h00000001},
    '{3'd7, 32'h00000000, 32'd5,          32'h00000000}
  };

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  // Reference behaviour written straight from the operation rules.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] d,
                                         input logic [31:0] amt);
    logic [W-1:0] r;
    int unsigned  n;
    r = d;
    case (op)
      3'd0, 3'd1: begin
        n = amt % W;
        if (op == 3'd1) n = (W - n) % W;
        for (int i = 0; i < int'(W); i++) r[i] = d[(i + n) % W];
      end
      3'd2: r = (amt >= W) ? '0 : d >> amt;
      3'd3: r = (amt >= W) ? '0 : d << amt;
      3'd4: r = (amt >= W) ? {W{d[W-1]}} : W'($signed(d) >>> amt);
      default: r = d;
    endcase
    return r;
  endfunction

  logic          stall_seen = 1'b0;
  logic [W-1:0]  st_data;
  logic          st_zero, st_ill;
  logic [TW-1:0] st_tag;

  always @(negedge clock) begin
    exp_t e;
    if (!clear) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_data", bus.out_data, st_data);
        check("stall_zero", bus.out_zero, st_zero);
        check("stall_illegal", bus.out_illegal, st_ill);
        check("stall_tag", bus.out_tag, st_tag);
      end
      if (bus.in_valid && bus.in_ready) begin
        e.data    = model(bus.in_op, bus.in_data, bus.in_amount);
        e.zero    = (e.data == '0);
        e.illegal = (bus.in_op > 3'd4);
        e.tag     = bus.in_tag;
        sb.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: tag %0h data %0h with nothing outstanding",
                   bus.out_tag, bus.out_data);
        end else begin
          e = sb.pop_front();
          check("result_data", bus.out_data, e.data);
          check("result_zero", bus.out_zero, e.zero);
          check("result_illegal", bus.out_illegal, e.illegal);
          check("result_tag", bus.out_tag, e.tag);
        end
      end
      stall_seen = bus.out_valid && !bus.out_ready;
      st_data    = bus.out_data;
      st_zero    = bus.out_zero;
      st_ill     = bus.out_illegal;
      st_tag     = bus.out_tag;
    end
  end

  // Called just after a posedge; returns just after the edge that accepted the op.
  task automatic send(input logic [2:0] op, input logic [31:0] data, input logic [31:0] amt,
                      input logic [TW-1:0] tag);
    int cyc = 0;
    bus.in_op     = op;
    bus.in_data   = data;
    bus.in_amount = amt;
    bus.in_tag    = tag;
    bus.in_valid  = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.in_ready) break;
      cyc++;
      if (cyc > 50) break;
    end
    if (cyc > 50) begin
      fail_now("send_timeout");
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((sb.size() != 0 || bus.out_valid) && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    if (cyc >= 100) fail_now("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amount = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_zero", bus.out_zero, 1'b0);
    check("rst_out_illegal", bus.out_illegal, 1'b0);
    check("rst_out_tag", bus.out_tag, '0);
    #11;
    clear = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clock);
    #1;

    foreach (vecs[i]) check($sformatf("model_vec%0d", i),
                            model(vecs[i].op, vecs[i].data, vecs[i].amt), vecs[i].exp);

    // First edge accepts, second edge presents the result.
    send(3'd0, 32'h80000001, 32'd1, 4'hA);
    check("lat_after_accept", bus.out_valid, 1'b0);
    @(posedge clock);
    #1;
    check("lat_valid", bus.out_valid, 1'b1);
    check("lat_data", bus.out_data, 32'hC0000000);
    check("lat_tag", bus.out_tag, 4'hA);
    drain();

    foreach (vecs[i]) send(vecs[i].op, vecs[i].data, vecs[i].amt, TW'(i));
    drain();

    fork
      begin
        for (int t = 1; t <= 4; t++) send(vecs[t].op, vecs[t].data, vecs[t].amt, TW'(t));
      end
      begin
        int cyc = 0;
        do begin
          @(posedge clock);
          #1;
          cyc++;
        end while (!bus.out_valid && cyc < 20);
        if (!bus.out_valid) fail_now("bp_first_result");
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(posedge clock);
          #1;
          check("bp_in_ready_low", bus.in_ready, 1'b0);
          check("bp_hold_tag", bus.out_tag, 4'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_back", bus.in_ready, 1'b1);
        for (int t = 1; t <= 4; t++) begin
          @(negedge clock);
          check("bp_no_gap_valid", bus.out_valid, 1'b1);
          check("bp_order_tag", bus.out_tag, TW'(t));
        end
      end
    join
    drain();

    send(3'd3, 32'h0000FFFF, 32'd4, 4'd5);
    send(3'd2, 32'hFFFF0000, 32'd4, 4'd6);
    clear = 1'b0;
    #1;
    check("flush_out_valid", bus.out_valid, 1'b0);
    sb.delete();
    @(posedge clock);
    #2;
    clear = 1'b1;
    #1;
    check("flush_in_ready", bus.in_ready, 1'b1);
    repeat (4) begin
      @(negedge clock);
      check("flush_no_stale", bus.out_valid, 1'b0);
    end
    @(posedge clock);
    #1;
    send(3'd1, 32'h80000001, 32'd4, 4'd7);
    check("fresh_after_accept", bus.out_valid, 1'b0);
    @(posedge clock);
    #1;
    check("fresh_valid", bus.out_valid, 1'b1);
    check("fresh_data", bus.out_data, 32'h00000018);
    check("fresh_tag", bus.out_tag, 4'd7);
    drain();

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] amt;
          case ($urandom_range(0, 3))
            0:       amt = $urandom_range(0, 31);
            1:       amt = $urandom_range(32, 70);
            2:       amt = $urandom;
            default: amt = 32'd0;
          endcase
          send(3'($urandom_range(0, 7)), $urandom, amt, TW'(i));
        end
      end
      begin
        repeat (120) begin
          @(posedge clock);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
